tick_uart_tx: RTL and testbench

Tick-paced serial transmitter. It consumes the one-cycle enable pulse from the team's clock divider, which pulses once every DIVISOR clk cycles. It frames parallel words as asynchronous serial frames: start bit, DATA_W data bits LSB first, optional parity, then STOP_BITS stop bits. It sits directly downstream of the divider in the CUT I/O interface and drives the serial line toward the host/test harness.

---
 rtl/tick_uart_tx_if.sv | 21 ++
 rtl/tick_uart_tx.sv | 141 ++++++++++++++
 tb/tb_tick_uart_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_uart_tx_if.sv
// Word handshake between a parallel source and the tick-paced serial transmitter.
// The master modport is the word source and the slave modport is the transmitter.
interface tick_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/tick_uart_tx.sv
// Async serial framer paced by a divider tick: start, DATA_W data bits LSB first,
// optional parity, then STOP_BITS stop bits. tx/busy/done are registered.
module tick_uart_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  tick_uart_tx_if.slave       s,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int unsigned     IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic            ODD_FLIP  = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic               stop_cnt;
  logic               parity;

  logic               final_stop_c;
  logic               ready_c;
  logic               accept_c;

  // The tick that ends the last stop bit can also take the next word back-to-back.
  assign final_stop_c = (state == ST_STOP) && tick && (stop_cnt == LAST_STOP);
  assign ready_c      = (state == ST_IDLE) || final_stop_c;
  assign accept_c     = s.s_valid && ready_c;
  assign s.s_ready    = ready_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      parity   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Ticks in IDLE are ignored, so a tick in the accept cycle never starts the frame.
        ST_IDLE: begin
          if (accept_c) begin
            shreg  <= s.s_data;
            parity <= (^s.s_data) ^ ODD_FLIP;
            busy   <= 1'b1;
            state  <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end

        // shreg[0] always holds the next data bit to put on the line.
        ST_DATA: begin
          if (tick) begin
            if (bit_idx != LAST_IDX) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end else if (PARITY_EN != 0) begin
              tx    <= parity;
              state <= ST_PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= ST_STOP;
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= stop_cnt + 1'b1;
            end else begin
              done <= 1'b1;
              if (accept_c) begin
                shreg  <= s.s_data;
                parity <= (^s.s_data) ^ ODD_FLIP;
                tx     <= 1'b0;
                state  <= ST_START;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Randomized scoreboard bench for tick_uart_tx over three framing configurations
// sharing one clock, reset and divider tick.
module tb_tick_uart_tx;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;

  int vecs = 0;
  int errs = 0;

  int unsigned div  = 10;
  int unsigned tcnt = 0;
  bit          stop_drv = 1'b0;
  event        drain_ev;

  always #5 clk = ~clk;

  task automatic chk1(input string name, input int cfg, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cfg%0d t=%0t: got %b expected %b", name, cfg, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] dir_word(input int cfg, input int i);
    logic [15:0] w;
    w = 16'h0000;
    case (cfg)
      0: w = (i == 0) ? 16'h00A5 : (i == 1) ? 16'h0055 : 16'h000F;
      1: w = (i == 0) ? 16'h0007 : (i == 1) ? 16'h0000 : 16'h00FF;
      default: w = (i == 0) ? 16'h0007 : (i == 1) ? 16'h001F : 16'h0000;
    endcase
    return w;
  endfunction

  // Divider model: div=0 gives an irregular tick, div=1 holds tick high.
  always @(posedge clk) begin
    #1;
    if (div == 0) begin
      tick = ($urandom_range(0, 2) == 0);
    end else begin
      tick = (tcnt == 0);
      tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned DW = (g == 2) ? 5 : 8;
    localparam int unsigned SB = (g == 1) ? 2 : 1;
    localparam int unsigned PE = (g == 0) ? 0 : 1;
    localparam int unsigned PO = (g == 2) ? 1 : 0;
    localparam logic [15:0] MASK = 16'((32'd1 << DW) - 1);

    logic tx;
    logic busy;
    logic done;

    tick_uart_tx_if #(.DATA_W(DW)) bus ();

    tick_uart_tx #(
      .DATA_W    (DW),
      .STOP_BITS (SB),
      .PARITY_EN (PE),
      .PARITY_ODD(PO)
    ) dut (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .s   (bus),
      .tx  (tx),
      .busy(busy),
      .done(done)
    );

    logic [15:0] wq[$];
    bit          line_q[$];
    bit          active   = 1'b0;
    bit          exp_tx   = 1'b1;
    bit          exp_done = 1'b0;

    // Expected line levels for one frame, built from the word the source issued.
    task automatic load_frame();
      logic [15:0] w;
      bit p;
      if (wq.size() == 0) begin
        chk1("word_issued", g, 1'b0, 1'b1);
        return;
      end
      w = wq.pop_front();
      p = (PO != 0);
      line_q.push_back(1'b0);
      for (int i = 0; i < int'(DW); i++) begin
        line_q.push_back(w[i]);
        p = p ^ w[i];
      end
      if (PE != 0) line_q.push_back(p);
      for (int i = 0; i < int'(SB); i++) line_q.push_back(1'b1);
    endtask

    // Source: directed words first (back-to-back), then random words and gaps.
    initial begin
      logic [15:0] w;
      int gap;
      int budget;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      @(posedge rst);
      #1;
      for (int n = 0; !stop_drv; n++) begin
        if (n < 3) begin
          w   = dir_word(g, n);
          gap = 0;
        end else begin
          w   = 16'($urandom()) & MASK;
          gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
        end
        repeat (gap) begin
          bus.s_data = DW'($urandom());
          @(posedge clk);
          #1;
        end
        wq.push_back(w);
        bus.s_valid = 1'b1;
        bus.s_data  = DW'(w);
        budget = 400;
        do begin
          @(negedge clk);
          budget--;
        end while (!(rst && bus.s_ready) && budget > 0);
        if (!(rst && bus.s_ready)) begin
          chk1("handshake_timeout", g, 1'b0, 1'b1);
          void'(wq.pop_back());
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = DW'($urandom());
      end
      bus.s_valid = 1'b0;
    end

    // Line model: each tick edge puts the next frame bit on tx; the tick after
    // the last stop bit pulses done and may start the next frame immediately.
    always @(negedge clk) begin : mon
      bit rdy;
      bit acc;
      if (!rst) begin
        chk1("rst_tx", g, tx, 1'b1);
        chk1("rst_busy", g, busy, 1'b0);
        chk1("rst_done", g, done, 1'b0);
        chk1("rst_ready", g, bus.s_ready, 1'b1);
        line_q.delete();
        active   = 1'b0;
        exp_tx   = 1'b1;
        exp_done = 1'b0;
      end else begin
        chk1("tx", g, tx, exp_tx);
        chk1("busy", g, busy, active);
        chk1("done", g, done, exp_done);
        rdy = !active || (tick && line_q.size() == 0);
        chk1("s_ready", g, bus.s_ready, rdy);
        acc = bus.s_valid && rdy;
        exp_done = 1'b0;
        if (!active) begin
          if (acc) begin
            load_frame();
            active = 1'b1;
          end
        end else if (tick) begin
          if (line_q.size() != 0) begin
            exp_tx = line_q.pop_front();
          end else begin
            exp_done = 1'b1;
            if (acc) begin
              load_frame();
              if (line_q.size() != 0) exp_tx = line_q.pop_front();
            end else begin
              active = 1'b0;
              exp_tx = 1'b1;
            end
          end
        end
      end
    end

    always @(negedge rst) begin
      #1;
      chk1("async_rst_tx", g, tx, 1'b1);
      chk1("async_rst_busy", g, busy, 1'b0);
      chk1("async_rst_done", g, done, 1'b0);
      chk1("async_rst_ready", g, bus.s_ready, 1'b1);
    end

    always @(drain_ev) begin
      chk1("drained", g, (wq.size() == 0) && !active, 1'b1);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    div = 10;
    repeat (1500) @(posedge clk);
    do_reset();
    div = 3;
    repeat (800) @(posedge clk);
    div = 1;
    repeat (400) @(posedge clk);
    do_reset();
    div = 0;
    repeat (800) @(posedge clk);
    div = 7;
    repeat (600) @(posedge clk);
    do_reset();
    div = 2;
    repeat (400) @(posedge clk);
    stop_drv = 1'b1;
    div = 4;
    repeat (800) @(posedge clk);
    @(negedge clk);
    -> drain_ev;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
